// File: rtl/cdc_reg_bridge.sv
// cdc_reg_bridge: parses 'W' addr data / 'R' addr commands from the CDC host
// byte stream into a small register file and returns one response byte per
// command. Registers are readable/writable; address 0xFF reads status_i.
module cdc_reg_bridge #(
   parameter int NUM_REGS       = 8,
   parameter int TIMEOUT_CYCLES = 48000
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic [7:0]            out_data_i,
   input  logic                  out_valid_i,
   output logic                  out_ready_o,
   output logic [7:0]            in_data_o,
   output logic                  in_valid_o,
   input  logic                  in_ready_i,
   input  logic [7:0]            status_i,
   output logic [NUM_REGS*8-1:0] regs_o,
   output logic                  wr_stb_o,
   output logic [3:0]            wr_addr_o
);

   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] CMD_READ  = 8'h52;
   localparam logic [7:0] RSP_ACK   = 8'h4B;
   localparam logic [7:0] RSP_NAK   = 8'h15;
   localparam logic [7:0] STAT_ADDR = 8'hFF;

   typedef enum logic [2:0] {IDLE, W_ADDR, W_DATA, R_ADDR, RESP} state_t;

   state_t     state_q;
   logic [7:0] addr_q;
   logic [15:0] cnt_q, cnt_d;
   logic       out_ready_q, in_valid_q, wr_stb_q;
   logic [7:0] in_data_q;
   logic [3:0] wr_addr_q;
   logic [7:0] regs_q [NUM_REGS];

   logic       accept;
   logic       timeout_hit;
   logic       wr_hit;
   logic       rd_hit;
   logic [7:0] rd_val;

   // Byte handshake, idle-timer next value and register-file address decode.
   always_comb begin
      // NOTE: every signal driven here gets a default first so no latch is inferred.
      accept      = out_valid_i && out_ready_q;
      cnt_d       = cnt_q + 16'd1;
      timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_d == 16'(TIMEOUT_CYCLES));
      wr_hit      = addr_q < 8'(NUM_REGS);
      rd_hit      = out_data_i < 8'(NUM_REGS);
      rd_val      = 8'h00;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (out_data_i == 8'(k)) rd_val = regs_q[k];
      end
   end

   // Command FSM with registered handshake, response and write-strobe outputs.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q     <= IDLE;
         addr_q      <= 8'h00;
         cnt_q       <= 16'd0;
         out_ready_q <= 1'b0;
         in_valid_q  <= 1'b0;
         in_data_q   <= 8'h00;
         wr_stb_q    <= 1'b0;
         wr_addr_q   <= 4'd0;
         // NOTE: the register file drives chip control pins, so it is reset
         // explicitly rather than treated as an uninitialised memory.
         for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= 8'h00;
      end else begin
         // NOTE: all state updates here are non-blocking so every register
         // samples the values from before this edge.
         wr_stb_q <= 1'b0;
         case (state_q)
            IDLE: begin
               out_ready_q <= 1'b1;
               cnt_q       <= 16'd0;
               if (accept) begin
                  if (out_data_i == CMD_WRITE) begin
                     state_q <= W_ADDR;
                  end else if (out_data_i == CMD_READ) begin
                     state_q <= R_ADDR;
                  end else begin
                     state_q     <= RESP;
                     out_ready_q <= 1'b0;
                     in_valid_q  <= 1'b1;
                     in_data_q   <= RSP_NAK;
                  end
               end
            end
            W_ADDR: begin
               if (accept) begin
                  addr_q  <= out_data_i;
                  cnt_q   <= 16'd0;
                  state_q <= W_DATA;
               end else if (timeout_hit) begin
                  cnt_q   <= 16'd0;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            W_DATA: begin
               if (accept) begin
                  cnt_q       <= 16'd0;
                  state_q     <= RESP;
                  out_ready_q <= 1'b0;
                  in_valid_q  <= 1'b1;
                  if (wr_hit) begin
                     for (int k = 0; k < NUM_REGS; k++) begin
                        if (addr_q == 8'(k)) regs_q[k] <= out_data_i;
                     end
                     wr_stb_q  <= 1'b1;
                     wr_addr_q <= addr_q[3:0];
                     in_data_q <= RSP_ACK;
                  end else begin
                     in_data_q <= RSP_NAK;
                  end
               end else if (timeout_hit) begin
                  cnt_q   <= 16'd0;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            R_ADDR: begin
               if (accept) begin
                  cnt_q       <= 16'd0;
                  state_q     <= RESP;
                  out_ready_q <= 1'b0;
                  in_valid_q  <= 1'b1;
                  if (rd_hit)                        in_data_q <= rd_val;
                  else if (out_data_i == STAT_ADDR)  in_data_q <= status_i;
                  else                               in_data_q <= RSP_NAK;
               end else if (timeout_hit) begin
                  cnt_q   <= 16'd0;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            RESP: begin
               cnt_q <= 16'd0;
               if (in_ready_i) begin
                  in_valid_q  <= 1'b0;
                  out_ready_q <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q     <= IDLE;
               out_ready_q <= 1'b1;
               in_valid_q  <= 1'b0;
            end
         endcase
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
      assign regs_o[8*g +: 8] = regs_q[g];
   end

   assign out_ready_o = out_ready_q;
   assign in_valid_o  = in_valid_q;
   assign in_data_o   = in_data_q;
   assign wr_stb_o    = wr_stb_q;
   assign wr_addr_o   = wr_addr_q;

endmodule

// File: tb/tb_cdc_reg_bridge.sv
// tb_cdc_reg_bridge: directed and randomized command traffic against a
// byte-level reference model of the register bridge.
module tb_cdc_reg_bridge;

   localparam int NREGS = 8;
   localparam int TMO   = 20;

   logic             clk_i = 1'b0;
   logic             rstn_i = 1'b0;
   logic [7:0]       out_data_i = 8'h00;
   logic             out_valid_i = 1'b0;
   logic             out_ready_o;
   logic [7:0]       in_data_o;
   logic             in_valid_o;
   logic             in_ready_i = 1'b1;
   logic [7:0]       status_i = 8'h00;
   logic [NREGS*8-1:0] regs_o;
   logic             wr_stb_o;
   logic [3:0]       wr_addr_o;

   cdc_reg_bridge #(.NUM_REGS(NREGS), .TIMEOUT_CYCLES(TMO)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i),
      .out_data_i(out_data_i), .out_valid_i(out_valid_i), .out_ready_o(out_ready_o),
      .in_data_o(in_data_o), .in_valid_o(in_valid_o), .in_ready_i(in_ready_i),
      .status_i(status_i), .regs_o(regs_o), .wr_stb_o(wr_stb_o), .wr_addr_o(wr_addr_o)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   logic [7:0] regs_m [NREGS];
   logic [3:0] last_wr_m = 4'd0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [NREGS*8-1:0] model_regs();
      logic [NREGS*8-1:0] v;
      for (int k = 0; k < NREGS; k++) v[8*k +: 8] = regs_m[k];
      return v;
   endfunction

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk_i); #1; end
   endtask

   // present one byte and hold it until the bridge accepts it (bounded)
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      out_data_i  = b;
      out_valid_i = 1'b1;
      @(negedge clk_i);
      while (!out_ready_o && n < 50) begin @(negedge clk_i); n++; end
      check("accept_ready", {63'd0, out_ready_o}, 64'd1);
      @(posedge clk_i); #1;
      out_valid_i = 1'b0;
   endtask

   // full command: nb bytes, idle gap before the last byte, optional response stall
   task automatic do_cmd(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input int nb, input int gap_last, input int stall, input bit push);
      logic [7:0] exp;
      logic       stb;
      stb = 1'b0;
      exp = 8'h15;
      if (b0 == 8'h57 && nb == 3) begin
         if (b1 < NREGS) begin
            regs_m[b1[2:0]] = b2;
            last_wr_m = b1[3:0];
            exp = 8'h4B;
            stb = 1'b1;
         end
      end else if (b0 == 8'h52 && nb == 2) begin
         if (b1 < NREGS)       exp = regs_m[b1[2:0]];
         else if (b1 == 8'hFF) exp = status_i;
      end
      if (nb > 1) send_byte(b0);
      if (nb > 2) send_byte(b1);
      idle(gap_last);
      in_ready_i = (stall == 0);
      case (nb)
         1: send_byte(b0);
         2: send_byte(b1);
         default: send_byte(b2);
      endcase
      check("resp_valid", {63'd0, in_valid_o}, 64'd1);
      check("resp_data", {56'd0, in_data_o}, {56'd0, exp});
      check("resp_ordy", {63'd0, out_ready_o}, 64'd0);
      check("wr_stb", {63'd0, wr_stb_o}, {63'd0, stb});
      check("regs", {{(64-NREGS*8){1'b0}}, regs_o}, {{(64-NREGS*8){1'b0}}, model_regs()});
      check("wr_addr", {60'd0, wr_addr_o}, {60'd0, last_wr_m});
      if (stall > 0) begin
         if (push) begin out_data_i = 8'h41; out_valid_i = 1'b1; end
         repeat (stall) begin
            @(posedge clk_i); #1;
            check("stall_valid", {63'd0, in_valid_o}, 64'd1);
            check("stall_data", {56'd0, in_data_o}, {56'd0, exp});
            check("stall_ordy", {63'd0, out_ready_o}, 64'd0);
         end
         out_valid_i = 1'b0;
         in_ready_i  = 1'b1;
      end
      @(posedge clk_i); #1;
      check("done_valid", {63'd0, in_valid_o}, 64'd0);
      check("done_ordy", {63'd0, out_ready_o}, 64'd1);
      check("done_stb", {63'd0, wr_stb_o}, 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] a, c, d;
      int kind;
      for (int k = 0; k < NREGS; k++) regs_m[k] = 8'h00;

      // reset state
      #12;
      check("rst_ordy", {63'd0, out_ready_o}, 64'd0);
      check("rst_valid", {63'd0, in_valid_o}, 64'd0);
      check("rst_data", {56'd0, in_data_o}, 64'd0);
      check("rst_regs", {{(64-NREGS*8){1'b0}}, regs_o}, 64'd0);
      check("rst_stb", {63'd0, wr_stb_o}, 64'd0);
      check("rst_waddr", {60'd0, wr_addr_o}, 64'd0);
      @(posedge clk_i); #1;
      rstn_i = 1'b1;
      check("rel_ordy_low", {63'd0, out_ready_o}, 64'd0);
      @(posedge clk_i); #1;
      check("rel_ordy_high", {63'd0, out_ready_o}, 64'd1);

      // directed cases
      do_cmd(8'h57, 8'h03, 8'hA5, 3, 0, 0, 0);
      check("reg3_a5", {56'd0, regs_o[31:24]}, 64'hA5);
      do_cmd(8'h57, 8'h03, 8'h5A, 3, 0, 0, 0);
      do_cmd(8'h52, 8'h03, 8'h00, 2, 0, 0, 0);
      status_i = 8'hC3;
      do_cmd(8'h52, 8'hFF, 8'h00, 2, 0, 0, 0);
      do_cmd(8'h57, 8'h08, 8'h11, 3, 0, 0, 0);
      do_cmd(8'h57, 8'hFF, 8'h22, 3, 0, 0, 0);
      do_cmd(8'h52, 8'h20, 8'h00, 2, 0, 0, 0);
      do_cmd(8'h41, 8'h00, 8'h00, 1, 0, 0, 0);
      do_cmd(8'h57, 8'h07, 8'h99, 3, 0, 0, 0);
      do_cmd(8'h52, 8'h07, 8'h00, 2, 0, 0, 0);

      // response stall with a host byte pending
      do_cmd(8'h52, 8'h03, 8'h00, 2, 0, 10, 1);
      do_cmd(8'h52, 8'h07, 8'h00, 2, 0, 0, 0);

      // timeout: full idle window aborts the write
      send_byte(8'h57);
      send_byte(8'h01);
      repeat (TMO) begin
         @(posedge clk_i); #1;
         check("tmo_valid", {63'd0, in_valid_o}, 64'd0);
         check("tmo_ordy", {63'd0, out_ready_o}, 64'd1);
      end
      do_cmd(8'h52, 8'h01, 8'h00, 2, 0, 0, 0);
      // one cycle short of the timeout the command still completes
      do_cmd(8'h57, 8'h02, 8'h66, 3, TMO - 1, 0, 0);
      do_cmd(8'h52, 8'h02, 8'h00, 2, TMO - 1, 0, 0);

      // randomized traffic
      for (int i = 0; i < 60; i++) begin
         status_i = 8'($urandom);
         case ($urandom % 4)
            0, 3:    a = 8'($urandom % NREGS);
            1:       a = 8'(NREGS + ($urandom % (256 - NREGS)));
            default: a = 8'hFF;
         endcase
         d    = 8'($urandom);
         kind = int'($urandom % 5);
         if (kind < 2) begin
            do_cmd(8'h57, a, d, 3, int'($urandom_range(0, TMO - 1)), int'($urandom_range(0, 3)), 1'($urandom));
         end else if (kind < 4) begin
            do_cmd(8'h52, a, 8'h00, 2, int'($urandom_range(0, TMO - 1)), int'($urandom_range(0, 3)), 1'($urandom));
         end else begin
            c = 8'($urandom);
            if (c == 8'h57 || c == 8'h52) c = 8'h00;
            do_cmd(c, 8'h00, 8'h00, 1, int'($urandom_range(0, 4)), 0, 0);
         end
      end

      // ensure a non-zero register, then reset between 'W' and its address
      do_cmd(8'h57, 8'h00, 8'hE7, 3, 0, 0, 0);
      send_byte(8'h57);
      #3;
      rstn_i = 1'b0;
      #1;
      for (int k = 0; k < NREGS; k++) regs_m[k] = 8'h00;
      last_wr_m = 4'd0;
      check("arst_regs", {{(64-NREGS*8){1'b0}}, regs_o}, 64'd0);
      check("arst_ordy", {63'd0, out_ready_o}, 64'd0);
      check("arst_valid", {63'd0, in_valid_o}, 64'd0);
      check("arst_data", {56'd0, in_data_o}, 64'd0);
      check("arst_waddr", {60'd0, wr_addr_o}, 64'd0);
      check("arst_stb", {63'd0, wr_stb_o}, 64'd0);
      @(posedge clk_i); #1;
      rstn_i = 1'b1;
      do_cmd(8'h52, 8'h00, 8'h00, 2, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
